// File: rtl/wb_serial_master.sv
// Wishbone bus master driven by a UART byte stream.
// Host sends read/write commands; the block runs one bus cycle and replies.
module wb_serial_master #(
    parameter int unsigned byte_timeout = 5000000,
    parameter int unsigned bus_timeout  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] RSP_OK   = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;
    localparam int unsigned BYTE_LAST = byte_timeout - 1;
    localparam int unsigned BUS_LAST  = bus_timeout - 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

    state_t      state;
    logic        is_wr;
    logic [1:0]  idx;
    logic [31:0] adr_sr;
    logic [31:0] dat_sr;
    logic [31:0] byte_tmr;
    logic [31:0] bus_tmr;
    logic [31:0] rsp_sr;
    logic [1:0]  rsp_left;

    logic bus_fail;
    assign bus_fail = wb_err_i | wb_rty_i |
                      (!wb_ack_i && (bus_tmr == BUS_LAST));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            idx      <= 2'd0;
            adr_sr   <= '0;
            dat_sr   <= '0;
            byte_tmr <= '0;
            bus_tmr  <= '0;
            rsp_sr   <= '0;
            rsp_left <= 2'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_cnt  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_valid &&
                        (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        is_wr    <= (rx_data == CMD_WR);
                        idx      <= 2'd0;
                        byte_tmr <= '0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        adr_sr   <= {adr_sr[23:0], rx_data};
                        byte_tmr <= '0;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            if (is_wr) begin
                                state <= DATA;
                            end else begin
                                wb_adr_o <= {adr_sr[23:0], rx_data};
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_sel_o <= 4'hF;
                                wb_we_o  <= 1'b0;
                                bus_tmr  <= '0;
                                state    <= BUS;
                            end
                        end
                    end else if (byte_tmr == BYTE_LAST) begin
                        state <= IDLE;
                    end else begin
                        byte_tmr <= byte_tmr + 32'd1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        dat_sr   <= {dat_sr[23:0], rx_data};
                        byte_tmr <= '0;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            wb_adr_o <= adr_sr;
                            wb_dat_o <= {dat_sr[23:0], rx_data};
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= 4'hF;
                            wb_we_o  <= 1'b1;
                            bus_tmr  <= '0;
                            state    <= BUS;
                        end
                    end else if (byte_tmr == BYTE_LAST) begin
                        state <= IDLE;
                    end else begin
                        byte_tmr <= byte_tmr + 32'd1;
                    end
                end
                BUS: begin
                    if (bus_fail || wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                        // err/rty outrank a coincident ack
                        if (bus_fail) begin
                            tx_data  <= RSP_ERR;
                            rsp_left <= 2'd0;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end else if (is_wr) begin
                            tx_data  <= RSP_OK;
                            rsp_left <= 2'd0;
                        end else begin
                            tx_data  <= wb_dat_i[31:24];
                            rsp_sr   <= {wb_dat_i[23:0], 8'h00};
                            rsp_left <= 2'd3;
                        end
                    end else begin
                        bus_tmr <= bus_tmr + 32'd1;
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        if (rsp_left == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data  <= rsp_sr[31:24];
                            rsp_sr   <= {rsp_sr[23:0], 8'h00};
                            rsp_left <= rsp_left - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master.
// Scripted slave responder plus a linear command sequence.
module tb_wb_serial_master;

    localparam int unsigned BT  = 40;
    localparam int unsigned BUS = 1024;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_RTY    = 2;
    localparam int M_NONE   = 3;
    localparam int M_ACKERR = 4;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_vec = 0;
    int n_err = 0;

    int          mode;
    int          ack_dly;
    int          stb_cycles;
    int          last_len;
    int          nbus;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [7:0]  got_q[4];
    bit          unstable;

    wb_serial_master #(
        .byte_timeout(BT),
        .bus_timeout (BUS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
        .wb_we_o (wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic active;
    assign active = wb_cyc_o && wb_stb_o && (stb_cycles == ack_dly);
    assign wb_ack_i = active && (mode == M_ACK || mode == M_ACKERR);
    assign wb_err_i = active && (mode == M_ERR || mode == M_ACKERR);
    assign wb_rty_i = active && (mode == M_RTY);

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (stb_cycles == 0) begin
                cap_adr <= wb_adr_o;
                cap_dat <= wb_dat_o;
                cap_we  <= wb_we_o;
                cap_sel <= wb_sel_o;
                nbus    <= nbus + 1;
            end
            stb_cycles <= stb_cycles + 1;
        end else begin
            if (stb_cycles != 0) last_len <= stb_cycles;
            stb_cycles <= 0;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_drop(input string tag, input int budget);
        int k;
        k = 0;
        while (wb_cyc_o && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, wb_cyc_o}, 32'd0);
    endtask

    task automatic recv(input int n, input bit rnd);
        bit          stall;
        bit          got;
        logic [7:0]  held;
        stall    = 1'b0;
        held     = 8'h00;
        unstable = 1'b0;
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                tx_ready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
                if (stall && tx_data !== held) unstable = 1'b1;
                if (tx_valid && tx_ready) begin
                    got_q[i] = tx_data;
                    got      = 1'b1;
                    stall    = 1'b0;
                end else begin
                    stall = tx_valid;
                    held  = tx_data;
                end
                tick();
            end
            n_vec++;
            assert (got) else begin
                n_err++;
                $error("FAIL rx_byte%0d: observed none expected byte", i);
            end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        int nb0;
        int seen;
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_dat_i = 32'h0;
        mode     = M_ACK;
        ack_dly  = 0;
        stb_cycles = 0;
        last_len = 0;
        nbus     = 0;
        cap_adr  = '0;
        cap_dat  = '0;
        cap_we   = 1'b0;
        cap_sel  = 4'h0;
        repeat (3) tick();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_errc", {24'd0, err_cnt}, 32'd0);
        reset_n = 1'b1;
        tick();

        // write
        mode    = M_ACK;
        ack_dly = 1;
        send_byte(8'h01);
        send_word(32'h00007F00);
        send_word(32'hDEADBEEF);
        chk("wr_stb_lat", {31'd0, wb_stb_o}, 32'd1);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        wait_drop("wr_drop", 50);
        chk("wr_adr", cap_adr, 32'h00007F00);
        chk("wr_dat", cap_dat, 32'hDEADBEEF);
        chk("wr_we", {31'd0, cap_we}, 32'd1);
        chk("wr_sel", {28'd0, cap_sel}, 32'hF);
        recv(1, 1'b0);
        chk("wr_rsp", {24'd0, got_q[0]}, 32'hA5);
        chk("wr_idle", {31'd0, busy}, 32'd0);

        // read with stalled transmitter
        ack_dly  = 3;
        wb_dat_i = 32'h12345678;
        send_byte(8'h02);
        send_word(32'h70000000);
        chk("rd_stb_lat", {31'd0, wb_stb_o}, 32'd1);
        wait_drop("rd_drop", 50);
        chk("rd_txv_lat", {31'd0, tx_valid}, 32'd1);
        chk("rd_adr", cap_adr, 32'h70000000);
        chk("rd_we", {31'd0, cap_we}, 32'd0);
        recv(4, 1'b1);
        chk("rd_b0", {24'd0, got_q[0]}, 32'h12);
        chk("rd_b1", {24'd0, got_q[1]}, 32'h34);
        chk("rd_b2", {24'd0, got_q[2]}, 32'h56);
        chk("rd_b3", {24'd0, got_q[3]}, 32'h78);
        chk("rd_stable", {31'd0, unstable}, 32'd0);
        chk("rd_idle", {31'd0, busy}, 32'd0);

        // bus error on first cycle
        mode    = M_ERR;
        ack_dly = 0;
        send_byte(8'h02);
        send_word(32'h00000010);
        wait_drop("err_drop", 50);
        recv(1, 1'b0);
        chk("err_rsp", {24'd0, got_q[0]}, 32'hEE);
        chk("err_cnt1", {24'd0, err_cnt}, 32'd1);

        // no termination: bus timeout
        mode = M_NONE;
        send_byte(8'h02);
        send_word(32'h00000020);
        wait_drop("to_drop", BUS + 50);
        tick();
        chk("to_len", last_len, BUS);
        recv(1, 1'b0);
        chk("to_rsp", {24'd0, got_q[0]}, 32'hEE);
        chk("err_cnt2", {24'd0, err_cnt}, 32'd2);

        // retry treated as error
        mode    = M_RTY;
        ack_dly = 1;
        send_byte(8'h02);
        send_word(32'h00000030);
        wait_drop("rty_drop", 50);
        recv(1, 1'b0);
        chk("rty_rsp", {24'd0, got_q[0]}, 32'hEE);
        chk("err_cnt3", {24'd0, err_cnt}, 32'd3);

        // junk byte then partial command left to time out
        send_byte(8'h55);
        chk("junk_idle", {31'd0, busy}, 32'd0);
        nb0 = nbus;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("part_busy", {31'd0, busy}, 32'd1);
        repeat (BT - 1) tick();
        chk("bto_edge", {31'd0, busy}, 32'd1);
        tick();
        chk("bto_idle", {31'd0, busy}, 32'd0);
        chk("bto_nobus", nbus, nb0);
        chk("bto_notx", {31'd0, tx_valid}, 32'd0);

        mode     = M_ACK;
        ack_dly  = 0;
        wb_dat_i = 32'hCAFEF00D;
        send_byte(8'h02);
        send_word(32'h00000040);
        wait_drop("rd2_drop", 50);
        chk("rd2_adr", cap_adr, 32'h00000040);
        recv(4, 1'b0);
        chk("rd2_b0", {24'd0, got_q[0]}, 32'hCA);
        chk("rd2_b3", {24'd0, got_q[3]}, 32'h0D);

        // ack and err together
        mode    = M_ACKERR;
        ack_dly = 2;
        send_byte(8'h02);
        send_word(32'h00000050);
        wait_drop("ae_drop", 50);
        recv(1, 1'b0);
        chk("ae_rsp", {24'd0, got_q[0]}, 32'hEE);
        chk("err_cnt4", {24'd0, err_cnt}, 32'd4);
        tick();
        chk("ae_notx", {31'd0, tx_valid}, 32'd0);
        chk("ae_idle", {31'd0, busy}, 32'd0);

        // reset while awaiting ack
        mode = M_NONE;
        send_byte(8'h02);
        send_word(32'h00000060);
        repeat (5) tick();
        chk("mr_stb", {31'd0, wb_stb_o}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mr_stb0", {31'd0, wb_stb_o}, 32'd0);
        chk("mr_txv", {31'd0, tx_valid}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_errc", {24'd0, err_cnt}, 32'd0);
        #3;
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        seen     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid || busy || wb_cyc_o) seen++;
        end
        tx_ready = 1'b0;
        chk("mr_quiet", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
